// File: rtl/adbg_pkg.sv
// Shared types and constants for the advanced debug interface burst datapath.
// The CRC width and seed are set by the external CRC32 generator.
package adbg_pkg;

    localparam int          CRC_WIDTH = 32;
    localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FIRST,
        START_BIT,
        SEND_DATA,
        SEND_CRC,
        DONE
    } adbg_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/adbg_piso.sv
// Loadable right-shift register with a bit counter and an end-of-word flag; load wins over shift.
// One-cycle update; holds everything while neither load nor shift is asserted.
module adbg_piso
    import adbg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_load_dat,
    input  logic                  i_shift,
    input  logic                  i_cnt_clr,
    output logic                  o_bit,
    output logic [CNT_W-1:0]      o_cnt,
    output logic                  o_last
);

    logic [DATA_WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0]      r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shreg <= i_load_dat;
            r_cnt   <= '0;
        end else if (i_shift) begin
            r_shreg <= {1'b0, r_shreg[DATA_WIDTH-1:1]};
            r_cnt   <= i_cnt_clr ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_bit  = r_shreg[0];
    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/adbg_burst_serializer.sv
// Burst-read serializer: '1' start bit, N words LSB first, then the external CRC32, one bit per shift strobe.
// Takes 1 + N*DATA_WIDTH + CRC_WIDTH strobes from first word to done; shift_en low freezes all state.
module adbg_burst_serializer
    import adbg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [CNT_WIDTH-1:0]  i_word_count,
    input  logic [DATA_WIDTH-1:0] i_word_data,
    input  logic                  i_word_valid,
    output logic                  o_word_ready,
    input  logic                  i_shift_en,
    output logic                  o_tdo,
    output logic                  o_crc_clr,
    output logic                  o_crc_enable,
    output logic                  o_crc_data,
    output logic                  o_crc_shift,
    input  logic                  i_crc_serial,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_underrun
);

    localparam int BCW = $clog2(max_int(DATA_WIDTH, CRC_WIDTH));

    adbg_state_t          r_state;
    adbg_state_t          w_state_nxt;
    logic [CNT_WIDTH-1:0] r_words;
    logic                 r_underrun;
    logic                 r_done_zero;

    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_load_dat;
    logic                  w_shift;
    logic                  w_cnt_clr;
    logic                  w_bit;
    logic [BCW-1:0]        w_bit_cnt;
    logic                  w_word_last;
    logic                  w_accept;
    logic                  w_zero_start;
    logic                  w_underrun_set;
    logic                  w_word_dec;

    adbg_piso #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (BCW)
    ) u_piso (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_load_dat (w_load_dat),
        .i_shift    (w_shift),
        .i_cnt_clr  (w_cnt_clr),
        .o_bit      (w_bit),
        .o_cnt      (w_bit_cnt),
        .o_last     (w_word_last)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_words     <= '0;
            r_underrun  <= 1'b0;
            r_done_zero <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_done_zero <= w_zero_start;
            if (w_accept) begin
                r_words    <= i_word_count;
                r_underrun <= 1'b0;
            end else begin
                if (w_word_dec && (r_words != '0)) begin
                    r_words <= r_words - 1'b1;
                end
                if (w_underrun_set) begin
                    r_underrun <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_load         = 1'b0;
        w_load_dat     = i_word_data;
        w_shift        = 1'b0;
        w_cnt_clr      = 1'b0;
        w_accept       = 1'b0;
        w_zero_start   = 1'b0;
        w_underrun_set = 1'b0;
        w_word_dec     = 1'b0;
        o_word_ready   = 1'b0;
        o_tdo          = 1'b0;
        o_crc_clr      = 1'b0;
        o_crc_enable   = 1'b0;
        o_crc_data     = 1'b0;
        o_crc_shift    = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_start) begin
                    if (i_word_count != '0) begin
                        w_accept    = 1'b1;
                        o_crc_clr   = 1'b1;
                        w_state_nxt = WAIT_FIRST;
                    end else begin
                        w_zero_start = 1'b1;
                    end
                end
            end
            // Strobes here shift out zeros that are neither counted nor CRC'd.
            WAIT_FIRST: begin
                o_word_ready = 1'b1;
                if (i_word_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = START_BIT;
                end
            end
            START_BIT: begin
                o_tdo = 1'b1;
                if (i_shift_en) begin
                    w_state_nxt = SEND_DATA;
                end
            end
            SEND_DATA: begin
                o_tdo = w_bit;
                if (i_shift_en) begin
                    o_crc_enable = 1'b1;
                    o_crc_data   = w_bit;
                    w_shift      = 1'b1;
                    if (w_word_last) begin
                        w_word_dec = 1'b1;
                        if (r_words > CNT_WIDTH'(1)) begin
                            // A missing word is replaced by zeros so the frame length never changes.
                            o_word_ready   = 1'b1;
                            w_load         = 1'b1;
                            w_load_dat     = i_word_valid ? i_word_data : '0;
                            w_underrun_set = ~i_word_valid;
                        end else begin
                            w_cnt_clr   = 1'b1;
                            w_state_nxt = SEND_CRC;
                        end
                    end
                end
            end
            SEND_CRC: begin
                o_tdo = i_crc_serial;
                if (i_shift_en) begin
                    o_crc_shift = 1'b1;
                    w_shift     = 1'b1;
                    if (w_bit_cnt == BCW'(CRC_WIDTH - 1)) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_busy     = (r_state != IDLE);
    assign o_done     = (r_state == DONE) | r_done_zero;
    assign o_underrun = r_underrun;

endmodule

// File: tb/tb_adbg_burst_serializer.sv
// Bench for adbg_burst_serializer: random bursts against a frame-level model, with an external CRC32 generator model.
module tb_adbg_burst_serializer;
    import adbg_pkg::*;

    localparam int          DW       = 32;
    localparam int          CW       = 16;
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic [CW-1:0] i_word_count;
    logic [DW-1:0] i_word_data;
    logic          i_word_valid;
    logic          o_word_ready;
    logic          i_shift_en;
    logic          o_tdo;
    logic          o_crc_clr;
    logic          o_crc_enable;
    logic          o_crc_data;
    logic          o_crc_shift;
    logic          i_crc_serial;
    logic          o_busy;
    logic          o_done;
    logic          o_underrun;

    int total = 0;
    int bad   = 0;

    logic [31:0] wq [8];
    bit          ok [8];
    bit          exp_s[$];
    bit          exp_d[$];
    logic [31:0] env_crc;

    always #5 i_clk = ~i_clk;

    adbg_burst_serializer #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_word_count (i_word_count),
        .i_word_data  (i_word_data),
        .i_word_valid (i_word_valid),
        .o_word_ready (o_word_ready),
        .i_shift_en   (i_shift_en),
        .o_tdo        (o_tdo),
        .o_crc_clr    (o_crc_clr),
        .o_crc_enable (o_crc_enable),
        .o_crc_data   (o_crc_data),
        .o_crc_shift  (o_crc_shift),
        .i_crc_serial (i_crc_serial),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_underrun   (o_underrun)
    );

    // External serial CRC32 generator: reflected polynomial, LSB out on the serial pin.
    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst)             env_crc <= CRC_INIT;
        else if (o_crc_clr)    env_crc <= CRC_INIT;
        else if (o_crc_enable) env_crc <= {1'b0, env_crc[31:1]} ^ ((env_crc[0] ^ o_crc_data) ? CRC_POLY : 32'h0);
        else if (o_crc_shift)  env_crc <= {1'b0, env_crc[31:1]};
    end
    assign i_crc_serial = env_crc[0];

    function automatic logic [8:0] outs();
        return {o_busy, o_tdo, o_done, o_underrun, o_crc_clr, o_crc_enable, o_crc_shift, o_crc_data, o_word_ready};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // mode 0: shift_en always high; 1: random shift_en and stray starts; 2: five-cycle stall mid word.
    task automatic run_burst(input int n, input int poll, input int mode, input int rst_at);
        int nxt = 0, wcnt = 0, strobes = 0, cyc = 0, last_sc = -1, done_cyc = -2;
        int pre_bad = 0, pre_bits = 0, mis = 0, stall_bad = 0, stall = 0;
        int en_cnt = 0, sh_cnt = 0, clr_cnt = 0, rdy_cnt = 0, rdy_bad = 0, viol = 0, dmis = 0;
        bit acc = 0, fin = 0, got_done = 0, was_rst = 0, exp_ur = 0;
        logic [31:0] w;
        logic [31:0] c;
        bit got_d[$];

        exp_s.delete();
        exp_d.delete();
        exp_s.push_back(1'b1);
        for (int i = 0; i < n; i++) begin
            w = (i == 0 || ok[i]) ? wq[i] : 32'h0;
            if (i > 0 && !ok[i]) exp_ur = 1;
            for (int b = 0; b < DW; b++) begin
                exp_s.push_back(w[b]);
                exp_d.push_back(w[b]);
            end
        end
        c = CRC_INIT;
        foreach (exp_d[k]) c = (c >> 1) ^ ((c[0] ^ exp_d[k]) ? CRC_POLY : 32'h0);
        for (int b = 0; b < CRC_WIDTH; b++) exp_s.push_back(c[b]);

        while (!fin && cyc < 4000) begin
            @(posedge i_clk); #1;
            i_start      = (cyc == 0) || (mode == 1 && cyc > 3 && $urandom_range(15, 0) == 0);
            i_word_count = (cyc == 0) ? CW'(n) : CW'($urandom_range(7, 0));
            if (mode == 2 && acc && strobes == 20 && stall < 5) begin
                i_shift_en = 1'b0;
                stall++;
            end else if (mode == 1) begin
                i_shift_en = ($urandom_range(9, 0) < 7);
            end else begin
                i_shift_en = 1'b1;
            end
            if (rst_at >= 0 && acc && strobes == rst_at) i_rst = 1'b1;
            if (!acc) begin
                i_word_valid = (wcnt >= poll);
                i_word_data  = (wcnt >= poll) ? wq[0] : $urandom;
            end else if (nxt < n) begin
                i_word_valid = ok[nxt];
                i_word_data  = ok[nxt] ? wq[nxt] : $urandom;
            end else begin
                i_word_valid = 1'($urandom_range(1, 0));
                i_word_data  = $urandom;
            end

            @(negedge i_clk);
            cyc++;
            if (i_rst) begin
                chk("rst_mid_outs", 64'(outs()), 64'h0);
                was_rst = 1;
                fin     = 1;
            end else begin
                if (o_crc_clr) clr_cnt++;
                if (o_crc_enable) begin
                    en_cnt++;
                    got_d.push_back(o_crc_data);
                end
                if (o_crc_shift) sh_cnt++;
                if ((o_crc_enable || o_crc_shift) && !i_shift_en) viol++;
                if (o_crc_enable && o_crc_shift) viol++;
                if (o_done) begin
                    done_cyc = cyc;
                    got_done = 1;
                    fin      = 1;
                end else if (o_busy) begin
                    if (!acc) begin
                        if (o_tdo) pre_bad++;
                        if (i_shift_en) pre_bits++;
                        if (o_word_ready && i_word_valid) begin
                            acc = 1;
                            nxt = 1;
                            rdy_cnt++;
                        end else begin
                            wcnt++;
                        end
                    end else begin
                        if (strobes < exp_s.size() && o_tdo !== exp_s[strobes]) begin
                            mis++;
                            if (!i_shift_en && mode == 2) stall_bad++;
                        end
                        if (o_word_ready) begin
                            rdy_cnt++;
                            nxt++;
                            if (!(i_shift_en && strobes > 0 && strobes % DW == 0)) rdy_bad++;
                        end
                        if (i_shift_en) begin
                            strobes++;
                            last_sc = cyc;
                        end
                    end
                end
            end
        end

        @(posedge i_clk); #1;
        i_start      = 1'b0;
        i_word_valid = 1'b0;
        i_shift_en   = 1'b0;
        if (was_rst) begin
            i_rst = 1'b0;
            @(negedge i_clk);
            chk("post_rst_idle", 64'(outs()), 64'h0);
            chk("rst_clr_count", clr_cnt, 1);
            return;
        end
        @(negedge i_clk);
        chk("done_seen", got_done, 1);
        chk("after_done", {o_done, o_busy, o_underrun}, {2'b00, exp_ur});
        chk("crc_clr_count", clr_cnt, 1);
        chk("wait_tdo_zero", pre_bad, 0);
        if (mode == 0) chk("wait_strobes", pre_bits, poll + 1);
        chk("strobes_to_done", strobes, 1 + n * DW + CRC_WIDTH);
        chk("done_latency", done_cyc, last_sc + 1);
        chk("tdo_stream", mis, 0);
        chk("crc_enable_count", en_cnt, n * DW);
        chk("crc_shift_count", sh_cnt, CRC_WIDTH);
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++)
            if (got_d[i] !== exp_d[i]) dmis++;
        chk("crc_data_bits", dmis, 0);
        chk("word_ready_count", rdy_cnt, n);
        chk("word_ready_timing", rdy_bad, 0);
        chk("crc_ctrl_rules", viol, 0);
        if (mode == 2) chk("stall_tdo", stall_bad, 0);
    endtask

    task automatic zero_count();
        @(posedge i_clk); #1;
        i_start      = 1'b1;
        i_word_count = '0;
        i_shift_en   = 1'b1;
        @(negedge i_clk);
        chk("zero_no_clr", {o_crc_clr, o_busy}, 2'b00);
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(negedge i_clk);
        chk("zero_done", {o_done, o_busy, o_crc_enable, o_crc_shift, o_tdo}, 5'b10000);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("zero_done_once", {o_done, o_busy}, 2'b00);
        i_shift_en = 1'b0;
    endtask

    task automatic all_ok();
        for (int i = 0; i < 8; i++) ok[i] = 1;
    endtask

    initial begin
        i_rst        = 1'b1;
        i_start      = 1'b0;
        i_word_count = '0;
        i_word_data  = '0;
        i_word_valid = 1'b0;
        i_shift_en   = 1'b0;
        for (int i = 0; i < 8; i++) wq[i] = $urandom;
        all_ok();
        repeat (2) @(negedge i_clk);
        chk("reset_outs", 64'(outs()), 64'h0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("idle_outs", 64'(outs()), 64'h0);

        wq[0] = 32'h0000_0001;
        run_burst(1, 0, 0, -1);

        wq[0] = 32'hA5A5_A5A5;
        run_burst(1, 10, 0, -1);

        wq[0] = 32'h1; wq[1] = 32'h2; wq[2] = 32'h3;
        run_burst(3, 0, 0, -1);

        wq[0] = $urandom; wq[1] = $urandom; ok[1] = 0;
        run_burst(2, 0, 0, -1);
        repeat (3) @(negedge i_clk);
        chk("underrun_sticky", o_underrun, 1'b1);

        all_ok();
        wq[0] = $urandom; wq[1] = $urandom;
        run_burst(2, 0, 2, -1);

        zero_count();

        wq[0] = $urandom; wq[1] = $urandom; wq[2] = $urandom; ok[1] = 0;
        run_burst(3, 0, 0, 50);

        all_ok();
        wq[0] = $urandom; wq[1] = $urandom;
        run_burst(2, 3, 0, -1);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) begin
                wq[i] = $urandom;
                ok[i] = ($urandom_range(3, 0) != 0);
            end
            run_burst(int'($urandom_range(4, 1)), int'($urandom_range(5, 0)), 1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

endmodule
